mem_stage_hs: RTL and testbench

- Parametrised memory stage with variable-latency data-memory handshake.
- Supersedes the fixed single-cycle memory stage: generalises data width (XLEN 32/64), adds a req/ack memory interface, upstream stall (o_rdy), misalignment/illegal-size traps and a response timeout.
- Sits between the execute stage and writeback; drives the MEM/WB register, including the selected writeback data.

---
 rtl/mem_stage_hs.sv | 172 +++++++++++++++++
 tb/tb_mem_stage_hs.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_hs.sv
// Memory stage with a req/ack data-memory handshake, lane alignment and trap detection.
// Drives the MEM/WB register; stalls upstream via o_rdy while a transaction is outstanding.
module mem_stage_hs #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_vld,
    output logic                o_rdy,
    input  logic [2:0]          i_opsel,
    input  logic                i_ren,
    input  logic                i_wen,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [XLEN-1:0]     i_wdata,
    input  logic [XLEN-1:0]     i_res,
    input  logic [4:0]          i_rd_waddr,
    input  logic                i_rd_wen,
    input  logic [ADDR_W-1:0]   i_pc,
    output logic                o_dmem_req,
    output logic [ADDR_W-1:0]   o_dmem_addr,
    output logic                o_dmem_wen,
    output logic [XLEN/8-1:0]   o_dmem_mask,
    output logic [XLEN-1:0]     o_dmem_wdata,
    input  logic                i_dmem_ack,
    input  logic [XLEN-1:0]     i_dmem_rdata,
    output logic                o_vld,
    output logic [XLEN-1:0]     o_wb_data,
    output logic [4:0]          o_rd_waddr,
    output logic                o_rd_wen,
    output logic [ADDR_W-1:0]   o_pc,
    output logic                o_trap,
    output logic [1:0]          o_trap_cause
);

    localparam int unsigned BYTES = XLEN / 8;
    localparam int unsigned OFFW  = $clog2(BYTES);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e          state;
    logic [7:0]      wait_cnt;
    logic [OFFW-1:0] lat_off;
    logic [1:0]      lat_size;
    logic            lat_uns;

    logic [OFFW-1:0]  off;
    logic [1:0]       size;
    logic [2:0]       off3;
    logic [2:0]       align_mask;
    logic [BYTES-1:0] lane_base;
    logic             illegal;
    logic             misaligned;
    logic             mem_op;
    logic [BYTES-1:0] req_mask;
    logic [XLEN-1:0]  req_wdata;

    assign o_rdy = (state == StIdle);

    // Request-side lane math on the incoming instruction.
    always_comb begin
        off        = i_addr[OFFW-1:0];
        size       = i_opsel[1:0];
        off3       = 3'(off);
        align_mask = 3'b000;
        lane_base  = '0;
        unique case (size)
            2'd0: begin align_mask = 3'b000; lane_base = BYTES'(8'h01); end
            2'd1: begin align_mask = 3'b001; lane_base = BYTES'(8'h03); end
            2'd2: begin align_mask = 3'b011; lane_base = BYTES'(8'h0F); end
            2'd3: begin align_mask = 3'b111; lane_base = BYTES'(8'hFF); end
        endcase
        illegal    = (size == 2'd3) && (XLEN == 32);
        misaligned = (off3 & align_mask) != 3'b000;
        mem_op     = i_ren | i_wen;
        req_mask   = lane_base << off;
        req_wdata  = i_wdata << {off, 3'b000};
    end

    logic [XLEN-1:0] ld_shift;
    logic [XLEN-1:0] ld_keep;
    logic            ld_sbit;
    logic [XLEN-1:0] ld_data;

    // Response-side alignment uses the offset/size latched at request time.
    always_comb begin
        ld_shift = i_dmem_rdata >> {lat_off, 3'b000};
        ld_keep  = '1;
        ld_sbit  = 1'b0;
        unique case (lat_size)
            2'd0: begin ld_keep = XLEN'(8'hFF);         ld_sbit = ld_shift[7];  end
            2'd1: begin ld_keep = XLEN'(16'hFFFF);      ld_sbit = ld_shift[15]; end
            2'd2: begin ld_keep = XLEN'(32'hFFFF_FFFF); ld_sbit = ld_shift[31]; end
            2'd3: begin ld_keep = '1;                   ld_sbit = 1'b0;         end
        endcase
        ld_data = (ld_shift & ld_keep) | ({XLEN{ld_sbit & ~lat_uns}} & ~ld_keep);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= StIdle;
            wait_cnt     <= '0;
            lat_off      <= '0;
            lat_size     <= '0;
            lat_uns      <= 1'b0;
            o_dmem_req   <= 1'b0;
            o_dmem_addr  <= '0;
            o_dmem_wen   <= 1'b0;
            o_dmem_mask  <= '0;
            o_dmem_wdata <= '0;
            o_vld        <= 1'b0;
            o_wb_data    <= '0;
            o_rd_waddr   <= '0;
            o_rd_wen     <= 1'b0;
            o_pc         <= '0;
            o_trap       <= 1'b0;
            o_trap_cause <= '0;
        end else begin
            o_vld <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (i_vld) begin
                        o_rd_waddr <= i_rd_waddr;
                        o_pc       <= i_pc;
                        o_wb_data  <= i_res;
                        o_rd_wen   <= i_rd_wen;
                        o_trap     <= 1'b0;
                        if (mem_op && (illegal || misaligned)) begin
                            o_vld        <= 1'b1;
                            o_trap       <= 1'b1;
                            o_rd_wen     <= 1'b0;
                            o_trap_cause <= illegal ? 2'd3 : (i_wen ? 2'd1 : 2'd0);
                        end else if (mem_op) begin
                            state        <= StWait;
                            wait_cnt     <= '0;
                            o_dmem_req   <= 1'b1;
                            o_dmem_addr  <= {i_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
                            o_dmem_wen   <= i_wen;
                            o_dmem_mask  <= req_mask;
                            o_dmem_wdata <= req_wdata;
                            lat_off      <= off;
                            lat_size     <= size;
                            lat_uns      <= i_opsel[2];
                        end else begin
                            o_vld <= 1'b1;
                        end
                    end
                end
                StWait: begin
                    // Ack is checked first so it wins over a simultaneous timeout.
                    if (i_dmem_ack) begin
                        state      <= StIdle;
                        o_dmem_req <= 1'b0;
                        o_vld      <= 1'b1;
                        if (!o_dmem_wen) o_wb_data <= ld_data;
                    end else if (wait_cnt == 8'(MAX_WAIT - 1)) begin
                        state        <= StIdle;
                        o_dmem_req   <= 1'b0;
                        o_vld        <= 1'b1;
                        o_trap       <= 1'b1;
                        o_trap_cause <= 2'd2;
                        o_rd_wen     <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Bench for mem_stage_hs: directed scenarios plus randomized ops against a byte-level model.
// Instance a is XLEN=32/MAX_WAIT=4; instance b is XLEN=64 for double-word paths.
module tb_mem_stage_hs;

    localparam int MW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        vld = 0, ren = 0, wen = 0, rd_wen = 0, ack = 0;
    logic [2:0]  opsel = 0;
    logic [31:0] addr = 0, wdata = 0, res = 0, pc = 0, rdata = 0;
    logic [4:0]  rd_waddr = 0;
    logic        rdy, req, d_wen, o_vld, o_rdwen, trap;
    logic [31:0] d_addr, d_wdata, wb, o_pc;
    logic [3:0]  d_mask;
    logic [4:0]  o_rd;
    logic [1:0]  cause;

    mem_stage_hs #(.XLEN(32), .ADDR_W(32), .MAX_WAIT(MW)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_vld(vld), .o_rdy(rdy), .i_opsel(opsel), .i_ren(ren),
        .i_wen(wen), .i_addr(addr), .i_wdata(wdata), .i_res(res), .i_rd_waddr(rd_waddr),
        .i_rd_wen(rd_wen), .i_pc(pc), .o_dmem_req(req), .o_dmem_addr(d_addr),
        .o_dmem_wen(d_wen), .o_dmem_mask(d_mask), .o_dmem_wdata(d_wdata), .i_dmem_ack(ack),
        .i_dmem_rdata(rdata), .o_vld(o_vld), .o_wb_data(wb), .o_rd_waddr(o_rd),
        .o_rd_wen(o_rdwen), .o_pc(o_pc), .o_trap(trap), .o_trap_cause(cause)
    );

    logic        b_vld = 0, b_ren = 0, b_wen = 0, b_rd_wen = 0, b_ack = 0;
    logic [2:0]  b_opsel = 0;
    logic [31:0] b_addr = 0, b_pc = 0;
    logic [63:0] b_wdata = 0, b_res = 0, b_rdata = 0;
    logic [4:0]  b_rd_waddr = 0;
    logic        b_rdy, b_req, b_d_wen, b_o_vld, b_o_rdwen, b_trap;
    logic [31:0] b_d_addr, b_o_pc;
    logic [63:0] b_d_wdata, b_wb;
    logic [7:0]  b_d_mask;
    logic [4:0]  b_o_rd;
    logic [1:0]  b_cause;

    mem_stage_hs #(.XLEN(64), .ADDR_W(32), .MAX_WAIT(15)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_vld(b_vld), .o_rdy(b_rdy), .i_opsel(b_opsel),
        .i_ren(b_ren), .i_wen(b_wen), .i_addr(b_addr), .i_wdata(b_wdata), .i_res(b_res),
        .i_rd_waddr(b_rd_waddr), .i_rd_wen(b_rd_wen), .i_pc(b_pc), .o_dmem_req(b_req),
        .o_dmem_addr(b_d_addr), .o_dmem_wen(b_d_wen), .o_dmem_mask(b_d_mask),
        .o_dmem_wdata(b_d_wdata), .i_dmem_ack(b_ack), .i_dmem_rdata(b_rdata),
        .o_vld(b_o_vld), .o_wb_data(b_wb), .o_rd_waddr(b_o_rd), .o_rd_wen(b_o_rdwen),
        .o_pc(b_o_pc), .o_trap(b_trap), .o_trap_cause(b_cause)
    );

    // Reference model: byte-by-byte gather, then sign fill above the accessed width.
    function automatic logic [63:0] m_load(input logic [63:0] raw, input int off,
                                           input int size, input bit uns, input int xlen);
        logic [63:0] v = '0;
        int n = 1 << size;
        for (int i = 0; i < n; i++) v[8*i +: 8] = raw[8*(off+i) +: 8];
        if (!uns && 8 * n < xlen && v[8*n-1]) for (int i = 8 * n; i < 64; i++) v[i] = 1'b1;
        if (xlen == 32) v[63:32] = '0;
        return v;
    endfunction

    function automatic logic [3:0] m_mask(input int off, input int size);
        logic [3:0] m = '0;
        for (int i = 0; i < (1 << size); i++) m[off+i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] wd, input int off);
        logic [31:0] w = '0;
        for (int i = 0; i + off < 4; i++) w[8*(off+i) +: 8] = wd[8*i +: 8];
        return w;
    endfunction

    // One full instruction on instance a; starts and ends at a negedge.
    task automatic run_op(input logic r, input logic w, input logic [2:0] os,
                          input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] rs,
                          input logic [4:0] rd, input logic rdw, input logic [31:0] p,
                          input logic [31:0] rdv, input int delay);
        int  size = int'(os[1:0]);
        int  off  = int'(ad[1:0]);
        bit  mem  = r | w;
        bit  ill  = (size == 3);
        bit  mis  = (off % (1 << size)) != 0;
        logic [31:0] exp_wb;
        vld = 1; ren = r; wen = w; opsel = os; addr = ad; wdata = wd; res = rs;
        rd_waddr = rd; rd_wen = rdw; pc = p;
        @(posedge clk); #1 vld = 0; ren = 0; wen = 0;
        @(negedge clk);
        if (!mem || ill || mis) begin
            checks++; if (o_vld !== 1'b1) begin errors++; $display("FAIL imm_vld got=%b exp=1", o_vld); end
            checks++; if (trap !== mem) begin errors++; $display("FAIL imm_trap got=%b exp=%b", trap, mem); end
            checks++; if (req !== 1'b0) begin errors++; $display("FAIL imm_req got=%b exp=0", req); end
            checks++; if (o_rd !== rd || o_pc !== p) begin errors++; $display("FAIL imm_rd_pc got=%h/%h exp=%h/%h", o_rd, o_pc, rd, p); end
            if (mem) begin
                checks++; if (cause !== (ill ? 2'd3 : (w ? 2'd1 : 2'd0))) begin errors++; $display("FAIL trap_cause got=%0d ill=%b w=%b", cause, ill, w); end
                checks++; if (o_rdwen !== 1'b0) begin errors++; $display("FAIL trap_rdwen got=%b exp=0", o_rdwen); end
            end else begin
                checks++; if (wb !== rs) begin errors++; $display("FAIL alu_wb got=%h exp=%h", wb, rs); end
                checks++; if (o_rdwen !== rdw) begin errors++; $display("FAIL alu_rdwen got=%b exp=%b", o_rdwen, rdw); end
            end
        end else begin
            checks++; if (req !== 1'b1 || o_vld !== 1'b0 || rdy !== 1'b0) begin errors++; $display("FAIL req_start req=%b vld=%b rdy=%b exp 1/0/0", req, o_vld, rdy); end
            checks++; if (d_addr !== {ad[31:2], 2'b00}) begin errors++; $display("FAIL req_addr got=%h exp=%h", d_addr, {ad[31:2], 2'b00}); end
            checks++; if (d_mask !== m_mask(off, size)) begin errors++; $display("FAIL req_mask got=%b exp=%b", d_mask, m_mask(off, size)); end
            checks++; if (d_wen !== w) begin errors++; $display("FAIL req_wen got=%b exp=%b", d_wen, w); end
            if (w) begin
                checks++; if (d_wdata !== m_wdata(wd, off)) begin errors++; $display("FAIL req_wdata got=%h exp=%h", d_wdata, m_wdata(wd, off)); end
            end
            exp_wb = w ? rs : m_load({32'h0, rdv}, off, size, os[2], 32)[31:0];
            for (int k = 0; k < MW; k++) begin
                ack = (k == delay); rdata = rdv;
                @(posedge clk); #1 ack = 0;
                @(negedge clk);
                if (k == delay) begin
                    checks++; if (o_vld !== 1'b1 || trap !== 1'b0) begin errors++; $display("FAIL resp_vld vld=%b trap=%b exp 1/0", o_vld, trap); end
                    checks++; if (wb !== exp_wb) begin errors++; $display("FAIL resp_wb got=%h exp=%h", wb, exp_wb); end
                    checks++; if (o_rdwen !== rdw || o_rd !== rd || o_pc !== p) begin errors++; $display("FAIL resp_rd got=%b/%h/%h exp=%b/%h/%h", o_rdwen, o_rd, o_pc, rdw, rd, p); end
                    checks++; if (req !== 1'b0 || rdy !== 1'b1) begin errors++; $display("FAIL resp_idle req=%b rdy=%b exp 0/1", req, rdy); end
                    break;
                end else if (k == MW - 1) begin
                    checks++; if (o_vld !== 1'b1 || trap !== 1'b1 || cause !== 2'd2) begin errors++; $display("FAIL timeout vld=%b trap=%b cause=%0d exp 1/1/2", o_vld, trap, cause); end
                    checks++; if (o_rdwen !== 1'b0 || req !== 1'b0 || rdy !== 1'b1) begin errors++; $display("FAIL timeout_idle rdwen=%b req=%b rdy=%b exp 0/0/1", o_rdwen, req, rdy); end
                end else begin
                    checks++; if (req !== 1'b1 || rdy !== 1'b0 || o_vld !== 1'b0 || d_addr !== {ad[31:2], 2'b00}) begin errors++; $display("FAIL wait_hold req=%b rdy=%b vld=%b addr=%h", req, rdy, o_vld, d_addr); end
                end
            end
        end
        ack = 1'($urandom_range(0, 1)); rdata = $urandom;
        @(posedge clk); #1 ack = 0;
        @(negedge clk);
        checks++; if (o_vld !== 1'b0 || req !== 1'b0 || rdy !== 1'b1) begin errors++; $display("FAIL idle_gap vld=%b req=%b rdy=%b exp 0/0/1", o_vld, req, rdy); end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (o_vld !== 0 || req !== 0 || trap !== 0 || cause !== 0) begin errors++; $display("FAIL reset_ctl vld=%b req=%b trap=%b cause=%0d exp 0", o_vld, req, trap, cause); end
        checks++; if (wb !== 0 || o_pc !== 0 || o_rd !== 0 || o_rdwen !== 0) begin errors++; $display("FAIL reset_wb wb=%h pc=%h rd=%h rdwen=%b exp 0", wb, o_pc, o_rd, o_rdwen); end
        checks++; if (d_addr !== 0 || d_mask !== 0 || d_wdata !== 0 || d_wen !== 0) begin errors++; $display("FAIL reset_dmem addr=%h mask=%b wdata=%h wen=%b exp 0", d_addr, d_mask, d_wdata, d_wen); end
        checks++; if (rdy !== 1'b1 || b_rdy !== 1'b1 || b_o_vld !== 1'b0) begin errors++; $display("FAIL reset_rdy rdy=%b b_rdy=%b b_vld=%b exp 1/1/0", rdy, b_rdy, b_o_vld); end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_lb();
        vld = 1; ren = 1; opsel = 3'b000; addr = 32'h1003; res = 32'h55; rd_waddr = 5; rd_wen = 1;
        pc = 32'h100;
        @(posedge clk); #1 vld = 0; ren = 0;
        @(negedge clk);
        checks++; if (req !== 1 || d_addr !== 32'h1000 || d_mask !== 4'b1000) begin errors++; $display("FAIL lb_req req=%b addr=%h mask=%b exp 1/1000/1000", req, d_addr, d_mask); end
        @(negedge clk);
        checks++; if (rdy !== 0 || req !== 1) begin errors++; $display("FAIL lb_wait rdy=%b req=%b exp 0/1", rdy, req); end
        @(negedge clk);
        ack = 1; rdata = 32'h80FF_FF00;
        @(posedge clk); #1 ack = 0;
        @(negedge clk);
        checks++; if (o_vld !== 1 || wb !== 32'hFFFF_FF80 || o_rdwen !== 1) begin errors++; $display("FAIL lb_resp vld=%b wb=%h rdwen=%b exp 1/ffffff80/1", o_vld, wb, o_rdwen); end
        @(negedge clk);
        checks++; if (o_vld !== 0) begin errors++; $display("FAIL lb_pulse vld=%b exp 0", o_vld); end
    endtask

    task automatic test_store_and_traps();
        run_op(0, 1, 3'b001, 32'h2002, 32'h0000_ABCD, 32'h77, 5'd3, 1'b0, 32'h104, 32'h0, 0);
        run_op(1, 0, 3'b010, 32'h3001, 32'h0, 32'h11, 5'd4, 1'b1, 32'h108, 32'h0, 0);
        run_op(0, 1, 3'b001, 32'h3003, 32'h1234, 32'h22, 5'd0, 1'b0, 32'h10C, 32'h0, 0);
        run_op(1, 0, 3'b011, 32'h5008, 32'h0, 32'h33, 5'd9, 1'b1, 32'h110, 32'h0, 0);
    endtask

    task automatic test_timeout();
        run_op(1, 0, 3'b101, 32'h4000, 32'h0, 32'h44, 5'd6, 1'b1, 32'h114, 32'hFFFF_8001, 10);
        ack = 1;
        repeat (2) @(posedge clk);
        #1 ack = 0;
        @(negedge clk);
        checks++; if (o_vld !== 0 || req !== 0 || rdy !== 1) begin errors++; $display("FAIL stray_ack vld=%b req=%b rdy=%b exp 0/0/1", o_vld, req, rdy); end
        run_op(1, 0, 3'b001, 32'h4002, 32'h0, 32'h45, 5'd7, 1'b1, 32'h118, 32'h8001_0000, MW - 1);
    endtask

    task automatic test_reset_wait();
        vld = 1; ren = 1; opsel = 3'b010; addr = 32'h6000; rd_waddr = 2; rd_wen = 1;
        @(posedge clk); #1 vld = 0; ren = 0;
        @(negedge clk);
        checks++; if (req !== 1) begin errors++; $display("FAIL rstw_req got=%b exp 1", req); end
        rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        checks++; if (req !== 0 || o_vld !== 0 || rdy !== 1) begin errors++; $display("FAIL rstw_drop req=%b vld=%b rdy=%b exp 0/0/1", req, o_vld, rdy); end
        run_op(1, 0, 3'b010, 32'h6004, 32'h0, 32'h0, 5'd2, 1'b1, 32'h120, 32'hCAFE_F00D, 1);
    endtask

    task automatic test_back_to_back_64();
        logic [63:0] r64 = {$urandom, $urandom};
        b_vld = 1; b_ren = 1; b_opsel = 3'b011; b_addr = 32'h5008; b_rd_waddr = 7; b_rd_wen = 1;
        b_pc = 32'h200; b_res = 64'hDEAD;
        @(posedge clk);
        #1 b_ren = 0; b_opsel = 0; b_res = 64'h1234_5678_9ABC_DEF0; b_rd_waddr = 8; b_pc = 32'h204;
        @(negedge clk);
        checks++; if (b_req !== 1 || b_d_addr !== 32'h5008 || b_d_mask !== 8'hFF || b_rdy !== 0) begin errors++; $display("FAIL ld64_req req=%b addr=%h mask=%h rdy=%b", b_req, b_d_addr, b_d_mask, b_rdy); end
        @(negedge clk);
        checks++; if (b_rdy !== 0 || b_o_vld !== 0) begin errors++; $display("FAIL ld64_hold rdy=%b vld=%b exp 0/0", b_rdy, b_o_vld); end
        b_ack = 1; b_rdata = r64;
        @(posedge clk); #1 b_ack = 0;
        @(negedge clk);
        checks++; if (b_o_vld !== 1 || b_wb !== r64 || b_o_rd !== 5'd7 || b_rdy !== 1) begin errors++; $display("FAIL ld64_resp vld=%b wb=%h rd=%0d exp 1/%h/7", b_o_vld, b_wb, b_o_rd, r64); end
        @(posedge clk); #1 b_vld = 0;
        @(negedge clk);
        checks++; if (b_o_vld !== 1 || b_wb !== 64'h1234_5678_9ABC_DEF0 || b_o_rd !== 5'd8 || b_trap !== 0) begin errors++; $display("FAIL add64 vld=%b wb=%h rd=%0d trap=%b", b_o_vld, b_wb, b_o_rd, b_trap); end
        @(negedge clk);
        checks++; if (b_o_vld !== 0) begin errors++; $display("FAIL add64_pulse vld=%b exp 0", b_o_vld); end
        b_vld = 1; b_ren = 1; b_opsel = 3'b010; b_addr = 32'h500C; b_rd_waddr = 9;
        @(posedge clk); #1 b_vld = 0; b_ren = 0;
        @(negedge clk);
        checks++; if (b_d_mask !== 8'hF0) begin errors++; $display("FAIL lw64_mask got=%h exp=f0", b_d_mask); end
        b_ack = 1; b_rdata = {32'h8000_0001, 32'h0};
        @(posedge clk); #1 b_ack = 0;
        @(negedge clk);
        checks++; if (b_wb !== 64'hFFFF_FFFF_8000_0001) begin errors++; $display("FAIL lw64_sext got=%h exp=ffffffff80000001", b_wb); end
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            int          kind = $urandom_range(0, 2);
            logic [31:0] a    = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            run_op(kind == 1, kind == 2, 3'($urandom_range(0, 7)), a, $urandom, $urandom,
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                   $urandom_range(0, MW + 1));
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_lb();
        test_store_and_traps();
        test_timeout();
        test_reset_wait();
        test_back_to_back_64();
        test_random(80);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
